alu_result_fifo: RTL

- Downstream buffer for the 8-bit ALU result stream; it sits directly after the ALU's registered output.
- The ALU has no backpressure: a result appears as a single-cycle valid pulse with a DATA_WIDTH+1 wide result. This block captures every pulse into a circular FIFO and re-issues the results over a valid/ready handshake to the consumer.
- Results arriving when no slot can be freed are dropped. Each drop increments a saturating counter and sets a sticky flag.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_result_fifo_mem.sv | 29 ++
 rtl/alu_result_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: operand/result widths and the
// ALU opcode encoding used when decoding result streams.
package alu_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int RESULT_WIDTH = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    INC = 2'b10,
    NOP = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_result_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module alu_result_fifo_mem
  import alu_pkg::*;
#(
  parameter int WIDTH      = RESULT_WIDTH,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Captures every ALU result pulse into a circular FIFO and re-issues it over a
// valid/ready handshake; results that cannot be stored are counted as drops.
module alu_result_fifo #(
  parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 8,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH:0]       data_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH:0]       data_o,
  output logic [ADDR_WIDTH:0]       count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  input  logic                      clr_ovf_i,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int RES_W = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0]     PTR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]       CNT_ONE  = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [ADDR_WIDTH:0]       CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1'b1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0]     wr_ptr_r;
  logic [ADDR_WIDTH-1:0]     rd_ptr_r;
  logic [ADDR_WIDTH:0]       count_r;
  logic                      overflow_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [RES_W-1:0] rd_data_s;

  // Status comes from the registered count only; ready_i feeds just the accept decision.
  assign empty_s = (count_r == {(ADDR_WIDTH + 1){1'b0}});
  assign full_s  = (count_r == CNT_FULL);
  assign pop_s   = !empty_s && ready_i;
  assign push_s  = rst_n && valid_i && (!full_s || pop_s);
  assign drop_s  = valid_i && full_s && !pop_s;

  alu_result_fifo_mem #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (data_i),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Pointers, occupancy and drop bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
      count_r    <= {(ADDR_WIDTH + 1){1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A drop coinciding with a clear restarts the count at one.
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (clr_ovf_i) begin
          drop_cnt_r <= DROP_ONE;
        end else if (drop_cnt_r != DROP_MAX) begin
          drop_cnt_r <= drop_cnt_r + DROP_ONE;
        end
      end else if (clr_ovf_i) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
      end
    end
  end

  assign valid_o    = !empty_s;
  assign data_o     = empty_s ? {RES_W{1'b0}} : rd_data_s;
  assign count_o    = count_r;
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule
